// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, state and ALU encodings plus instruction field offsets
package cpu_pkg;
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3, S_DONE = 3'd4} state_t;
   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_MOVE = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam int RY_LSB = 0;
   // instruction layout is [opcode | rx | ry], MSB first
   function automatic int opc_lsb(input int w);
      return 2 * w;
   endfunction
   function automatic int rx_lsb(input int w);
      return w;
   endfunction
endpackage

// File: rtl/reg_onehot_decoder.sv
// reg_onehot_decoder: register select to one-hot enable, zero when disabled or out of range
module reg_onehot_decoder #(
   parameter int NUM_REGS  = 8,
   parameter int REG_SEL_W = 3
) (
   input  logic                 en,
   input  logic [REG_SEL_W-1:0] sel,
   output logic [NUM_REGS-1:0]  onehot
);
   assign onehot = (en && int'(sel) < NUM_REGS) ? NUM_REGS'(1) << sel : '0;
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the bus datapath with start/done handshake
module cpu_control_unit import cpu_pkg::*; #(
   parameter int NUM_REGS  = 8,
   parameter int REG_SEL_W = 3,
   localparam int INSTR_W  = 3 + 2 * REG_SEL_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [INSTR_W-1:0]  instruction,
   output logic [NUM_REGS-1:0] in_reg,
   output logic [NUM_REGS-1:0] out_reg,
   output logic                data,
   output logic                Ain,
   output logic                Gin,
   output logic                Gout,
   output logic [1:0]          alu_op,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic [2:0]          curr_state
);
   state_t               st;
   logic [INSTR_W-1:0]   ir;
   logic                 ill;
   logic [2:0]           op, iop;
   logic [REG_SEL_W-1:0] rx, ry, irx, iry, out_sel;
   logic                 ill_in, is_alu, t1ok, in_en, out_en, exec;
   assign op  = ir[opc_lsb(REG_SEL_W) +: 3];
   assign rx  = ir[rx_lsb(REG_SEL_W) +: REG_SEL_W];
   assign ry  = ir[RY_LSB +: REG_SEL_W];
   assign iop = instruction[opc_lsb(REG_SEL_W) +: 3];
   assign irx = instruction[rx_lsb(REG_SEL_W) +: REG_SEL_W];
   assign iry = instruction[RY_LSB +: REG_SEL_W];
   // LOAD never reads ry, so its ry field is free to hold anything
   assign ill_in = iop > OP_AND || int'(irx) >= NUM_REGS || (iop != OP_LOAD && int'(iry) >= NUM_REGS);
   always_ff @(posedge clk) begin
      if (!rst) begin
         st  <= S_IDLE;
         ir  <= '0;
         ill <= 1'b0;
      end else begin
         case (st)
            S_IDLE: if (start) begin
               st  <= S_T1;
               ir  <= instruction;
               ill <= ill_in;
            end
            S_T1:    st <= (ill || !is_alu) ? S_DONE : S_T2;
            S_T2:    st <= S_T3;
            S_T3:    st <= S_DONE;
            default: st <= S_IDLE;
         endcase
      end
   end
   assign is_alu     = op inside {OP_ADD, OP_SUB, OP_AND};
   assign t1ok       = st == S_T1 && !ill;
   assign exec       = !ill && is_alu && st inside {S_T1, S_T2, S_T3};
   assign data       = t1ok && op == OP_LOAD;
   assign Ain        = t1ok && is_alu;
   assign Gin        = st == S_T2;
   assign Gout       = st == S_T3;
   assign done       = st == S_DONE;
   assign illegal    = done && ill;
   assign busy       = st inside {S_T1, S_T2, S_T3, S_DONE};
   assign curr_state = busy ? st : 3'd0;
   assign alu_op     = !exec ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_ADD;
   assign in_en      = (t1ok && (op == OP_LOAD || op == OP_MOVE)) || st == S_T3;
   assign out_en     = (t1ok && op != OP_LOAD) || st == S_T2;
   assign out_sel    = (st == S_T1 && is_alu) ? rx : ry;
   reg_onehot_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_in_dec (
      .en(in_en), .sel(rx), .onehot(in_reg)
   );
   reg_onehot_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_out_dec (
      .en(out_en), .sel(out_sel), .onehot(out_reg)
   );
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed scoreboard bench for the 8- and 6-register control units
module tb_cpu_control_unit;
   typedef logic [27:0] vec_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [8:0] instruction = '0;
   logic [7:0] in_reg, out_reg;
   logic [5:0] in_reg6, out_reg6;
   logic       data, Ain, Gin, Gout, busy, done, illegal;
   logic       data6, Ain6, Gin6, Gout6, busy6, done6, illegal6;
   logic [1:0] alu_op, alu_op6;
   logic [2:0] curr_state, curr_state6;
   vec_t       q[$];
   int         passed = 0;
   int         total = 0;
   always #5 clk = ~clk;
   cpu_control_unit #(.NUM_REGS(8), .REG_SEL_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .instruction(instruction),
      .in_reg(in_reg), .out_reg(out_reg), .data(data), .Ain(Ain), .Gin(Gin), .Gout(Gout),
      .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal), .curr_state(curr_state)
   );
   cpu_control_unit #(.NUM_REGS(6), .REG_SEL_W(3)) dut6 (
      .clk(clk), .rst(rst), .start(start), .instruction(instruction),
      .in_reg(in_reg6), .out_reg(out_reg6), .data(data6), .Ain(Ain6), .Gin(Gin6), .Gout(Gout6),
      .alu_op(alu_op6), .busy(busy6), .done(done6), .illegal(illegal6), .curr_state(curr_state6)
   );
   function automatic vec_t v(input int st, input logic [7:0] inr, input logic [7:0] outr,
                              input logic d, input logic a, input logic g, input logic go,
                              input logic [1:0] op, input logic dn, input logic il);
      return {inr, outr, d, a, g, go, op, st != 0, dn, il, 3'(st)};
   endfunction
   task automatic step(input string tag, input bit six);
      vec_t obs, exp;
      @(posedge clk);
      #1;
      obs = six ? {2'b0, in_reg6, 2'b0, out_reg6, data6, Ain6, Gin6, Gout6, alu_op6, busy6, done6, illegal6, curr_state6}
                : {in_reg, out_reg, data, Ain, Gin, Gout, alu_op, busy, done, illegal, curr_state};
      exp = (q.size() == 0) ? 'x : q.pop_front();
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   initial begin
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("reset", 0);
      rst = 1'b1;
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("idle", 0);
      // LOAD r5
      start = 1'b1; instruction = 9'b000_101_000;
      q.push_back(v(1, 8'h20, 0, 1, 0, 0, 0, 0, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("load_t1", 0);
      start = 1'b0;
      step("load_done", 0);
      step("load_idle", 0);
      // SUB r2,r6
      start = 1'b1; instruction = 9'b011_010_110;
      q.push_back(v(1, 0, 8'h04, 0, 1, 0, 0, 2'b01, 0, 0));
      q.push_back(v(2, 0, 8'h40, 0, 0, 1, 0, 2'b01, 0, 0));
      q.push_back(v(3, 8'h04, 0, 0, 0, 0, 1, 2'b01, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("sub_t1", 0);
      start = 1'b0;
      step("sub_t2", 0);
      step("sub_t3", 0);
      step("sub_done", 0);
      step("sub_idle", 0);
      // illegal opcode on the 8-register unit
      start = 1'b1; instruction = 9'b111_000_000;
      q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      step("op7_t1", 0);
      start = 1'b0;
      step("op7_done", 0);
      // MOVE r1,r7 is out of range for six registers
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("six_idle", 1);
      start = 1'b1; instruction = 9'b001_001_111;
      q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("six_move_t1", 1);
      start = 1'b0;
      step("six_move_done", 1);
      step("six_move_idle", 1);
      start = 1'b1; instruction = 9'b110_001_111;
      q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("six_op6_t1", 1);
      start = 1'b0;
      step("six_op6_done", 1);
      step("six_op6_idle", 1);
      // start held high: MOVE r3,r1 accepted every third edge
      start = 1'b1; instruction = 9'b001_011_001;
      for (int i = 0; i < 3; i++) begin
         q.push_back(v(1, 8'h08, 8'h02, 0, 0, 0, 0, 0, 0, 0));
         q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 0; i < 9; i++) begin
         if (i == 8) start = 1'b0;
         step($sformatf("held_%0d", i), 0);
      end
      // reset in T2 of ADD r1,r2
      start = 1'b1; instruction = 9'b010_001_010;
      q.push_back(v(1, 0, 8'h02, 0, 1, 0, 0, 0, 0, 0));
      q.push_back(v(2, 0, 8'h04, 0, 0, 1, 0, 0, 0, 0));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("rst_add_t1", 0);
      start = 1'b0;
      step("rst_add_t2", 0);
      rst = 1'b0;
      step("rst_add_reset", 0);
      rst = 1'b1;
      step("rst_add_after1", 0);
      step("rst_add_after2", 0);
      // ADD r4,r3 with the input switched to AND after acceptance
      start = 1'b1; instruction = 9'b010_100_011;
      q.push_back(v(1, 0, 8'h10, 0, 1, 0, 0, 0, 0, 0));
      q.push_back(v(2, 0, 8'h08, 0, 0, 1, 0, 0, 0, 0));
      q.push_back(v(3, 8'h10, 0, 0, 0, 0, 1, 0, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step("latch_t1", 0);
      start = 1'b0; instruction = 9'b100_001_010;
      step("latch_t2", 0);
      step("latch_t3", 0);
      step("latch_done", 0);
      step("latch_idle", 0);
      // AND r0,r7 to cover the AND encoding
      start = 1'b1; instruction = 9'b100_000_111;
      q.push_back(v(1, 0, 8'h01, 0, 1, 0, 0, 2'b10, 0, 0));
      q.push_back(v(2, 0, 8'h80, 0, 0, 1, 0, 2'b10, 0, 0));
      q.push_back(v(3, 8'h01, 0, 0, 0, 0, 1, 2'b10, 0, 0));
      q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step("and_t1", 0);
      start = 1'b0;
      step("and_t2", 0);
      step("and_t3", 0);
      step("and_done", 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
